instr_fetch_unit: RTL and testbench

- Instruction fetch stage of the 5-stage pipelined ARM (LEGv8) CPU.
- Owns the PC, drives the instruction memory address, and loads the IF/ID pipeline register.
- Produces the 11-bit opcode slice and the instruction word that the decode/control logic consumes.
- Takes back from ID the branch decisions (uncondBr, branch-taken, branchReg, IF_ID_flush) and applies PC redirect, flush and stall.

---
 rtl/instr_fetch_unit.sv | 75 +++++++
 tb/tb_instr_fetch_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the pipelined LEGv8 core: owns the PC, reads instruction memory
// and loads the IF/ID register, applying branch redirects, flushes and stalls from ID.
module instr_fetch_unit #(
  parameter int unsigned       PC_W      = 64,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'hD503201F
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            uncondBr,
  input  logic            brTaken,
  input  logic            branchReg,
  input  logic [PC_W-1:0] regTarget,
  input  logic            IF_ID_flush,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     if_id_instr,
  output logic [10:0]     if_id_opcode,
  output logic [PC_W-1:0] if_id_pc,
  output logic [PC_W-1:0] if_id_link,
  output logic            if_id_valid
);

  logic [PC_W-1:0] imm26Off;
  logic [PC_W-1:0] imm19Off;
  logic [PC_W-1:0] b26Target;
  logic [PC_W-1:0] b19Target;
  logic [PC_W-1:0] pcNext;

  // Word offsets sign-extended and scaled to bytes; sums wrap modulo 2^PC_W.
  assign imm26Off  = {{(PC_W-28){if_id_instr[25]}}, if_id_instr[25:0], 2'b00};
  assign imm19Off  = {{(PC_W-21){if_id_instr[23]}}, if_id_instr[23:5], 2'b00};
  assign b26Target = if_id_pc + imm26Off;
  assign b19Target = if_id_pc + imm19Off;

  always_comb begin
    pcNext = pc + PC_W'(4);
    if (stall) begin
      pcNext = pc;
    end else if (branchReg) begin
      pcNext = regTarget;
    end else if (uncondBr) begin
      pcNext = b26Target;
    end else if (brTaken) begin
      pcNext = b19Target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= pcNext;
      if_id_pc <= pc;
      // A flushed slot still records its PC so the bubble stays traceable.
      if (IF_ID_flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else begin
        if_id_instr <= imem_rdata;
        if_id_valid <= 1'b1;
      end
    end
  end

  assign imem_addr    = pc;
  assign if_id_opcode = if_id_instr[31:21];
  assign if_id_link   = if_id_pc + PC_W'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, B delay slot, flushed CBZ,
// BR priority, stall hold and asynchronous reset against hand-computed values.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        uncondBr;
  logic        brTaken;
  logic        branchReg;
  logic [63:0] regTarget;
  logic        IF_ID_flush;
  logic [63:0] pc;
  logic [31:0] if_id_instr;
  logic [10:0] if_id_opcode;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_link;
  logic        if_id_valid;

  logic [31:0] mem [0:255];
  int          nCmp;
  int          nErr;
  logic [31:0] nopWord;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .uncondBr    (uncondBr),
    .brTaken     (brTaken),
    .branchReg   (branchReg),
    .regTarget   (regTarget),
    .IF_ID_flush (IF_ID_flush),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_opcode(if_id_opcode),
    .if_id_pc    (if_id_pc),
    .if_id_link  (if_id_link),
    .if_id_valid (if_id_valid)
  );

  assign imem_rdata = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkState(input string tag, input logic [63:0] pcExp, input logic [63:0] ifPcExp,
                          input logic [31:0] instrExp, input logic validExp);
    logic [31:0] ie;
    ie = instrExp;
    chk({tag, ".pc"},     pc,                   pcExp);
    chk({tag, ".addr"},   imem_addr,            pcExp);
    chk({tag, ".ifpc"},   if_id_pc,             ifPcExp);
    chk({tag, ".instr"},  {32'h0, if_id_instr}, {32'h0, instrExp});
    chk({tag, ".opcode"}, {53'h0, if_id_opcode}, {53'h0, ie[31:21]});
    chk({tag, ".link"},   if_id_link,           ifPcExp + 64'd4);
    chk({tag, ".valid"},  {63'h0, if_id_valid}, {63'h0, validExp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nCmp = 0;
    nErr = 0;
    nopWord = 32'hD503201F;
    for (int i = 0; i < 256; i++) mem[i] = 32'h8B000000 + i;
    mem[2]  = 32'h14000003;  // B #3 at 0x8
    mem[10] = 32'hB4FFFFC0;  // CBZ X0, #-2 at 0x28

    rst = 1'b0; stall = 1'b0; uncondBr = 1'b0; brTaken = 1'b0; branchReg = 1'b0;
    regTarget = 64'h0; IF_ID_flush = 1'b0;
    #1 rst = 1'b1;
    #2;
    chkState("reset", 64'h0, 64'h0, nopWord, 1'b0);
    #5 rst = 1'b0;

    // Sequential fetch
    step(); chkState("seq1", 64'd4,  64'd0,  32'h8B000000, 1'b1);
    step(); chkState("seq2", 64'd8,  64'd4,  32'h8B000001, 1'b1);
    step(); chkState("seq3", 64'd12, 64'd8,  32'h14000003, 1'b1);
    step(); chkState("seq4", 64'd16, 64'd12, 32'h8B000003, 1'b1);

    // Advance until the CBZ at 40 sits in IF/ID
    for (int i = 0; i < 7; i++) step();
    chkState("cbzIn", 64'd44, 64'd40, 32'hB4FFFFC0, 1'b1);
    brTaken = 1'b1; IF_ID_flush = 1'b1;
    step(); chkState("cbzTaken", 64'd32, 64'd44, nopWord, 1'b0);
    brTaken = 1'b0; IF_ID_flush = 1'b0;
    step(); chkState("cbzAfter", 64'd36, 64'd32, 32'h8B000008, 1'b1);

    // BR beats B when both are asserted
    branchReg = 1'b1; uncondBr = 1'b1; regTarget = 64'h100;
    step(); chkState("brPrio", 64'h100, 64'd36, 32'h8B000009, 1'b1);
    branchReg = 1'b0; uncondBr = 1'b0;

    // Stall holds everything and masks redirect/flush
    stall = 1'b1; brTaken = 1'b1; IF_ID_flush = 1'b1;
    step(); chkState("stall1", 64'h100, 64'd36, 32'h8B000009, 1'b1);
    step(); chkState("stall2", 64'h100, 64'd36, 32'h8B000009, 1'b1);
    step(); chkState("stall3", 64'h100, 64'd36, 32'h8B000009, 1'b1);
    stall = 1'b0; brTaken = 1'b0; IF_ID_flush = 1'b0;
    step(); chkState("stallEnd", 64'h104, 64'h100, 32'h8B000040, 1'b1);

    // Asynchronous reset mid-cycle with a redirect pending
    brTaken = 1'b1; IF_ID_flush = 1'b1;
    #3 rst = 1'b1;
    #1;
    chkState("asyncRst", 64'h0, 64'h0, nopWord, 1'b0);
    #2 rst = 1'b0; brTaken = 1'b0; IF_ID_flush = 1'b0;

    step(); chkState("re1", 64'd4,  64'd0, 32'h8B000000, 1'b1);
    step(); chkState("re2", 64'd8,  64'd4, 32'h8B000001, 1'b1);
    step(); chkState("re3", 64'd12, 64'd8, 32'h14000003, 1'b1);

    // B with imm26=3: target 20, delay slot at 12 still enters IF/ID
    uncondBr = 1'b1;
    step(); chkState("bTaken", 64'd20, 64'd12, 32'h8B000003, 1'b1);
    uncondBr = 1'b0;
    step(); chkState("bAfter", 64'd24, 64'd20, 32'h8B000005, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
